// File: rtl/alloc_ctrl.sv
// Allocation controller handing out BQ/LQ/SQ entries to decode, with in-order
// release and squash rewind. Optional stall counters: define ALLOC_CTRL_STATS_EN.

module alloc_ring #(
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          alloc,
  input  logic          rel,
  input  logic          squash_valid,
  input  logic [PW-1:0] squash_ptr,
  output logic [PW-2:0] tail_idx,
  output logic          full
);
  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [PW-1:0] count;
  logic [PW-1:0] squash_off, live_span;
  logic          empty;

  assign count    = tail_reg - head_reg;
  assign empty    = (head_reg == tail_reg);
  assign full     = (count == PW'(DEPTH));
  assign tail_idx = tail_reg[PW-2:0];

  always_comb begin
    head_next = head_reg;
    if (rel && !empty)
      head_next = head_reg + PW'(1);
    tail_next = tail_reg;
    if (squash_valid)
      tail_next = squash_ptr;
    else if (alloc)
      tail_next = tail_reg + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      head_reg <= head_next;
      tail_reg <= tail_next;
    end
  end

  // A legal squash pointer lies between the post-release head and the old tail.
  assign squash_off = squash_ptr - head_next;
  assign live_span  = tail_reg - head_next;

  always @(posedge clk) begin
    if (rstn) begin
      assert (!(rel && empty));
      assert (!squash_valid || (squash_off <= live_span));
    end
  end
endmodule

module alloc_ctrl #(
  parameter int  BQ_DEPTH = 8,
  parameter int  LQ_DEPTH = 16,
  parameter int  SQ_DEPTH = 16,
  localparam int BP = $clog2(BQ_DEPTH) + 1,
  localparam int LP = $clog2(LQ_DEPTH) + 1,
  localparam int SP = $clog2(SQ_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req_valid,
  input  logic          req_bq,
  input  logic          req_lq,
  input  logic          req_sq,
  output logic          req_ready,
  output logic [BP-2:0] bqid_o,
  output logic [LP-2:0] lqid_o,
  output logic [SP-2:0] sqid_o,
  input  logic          rel_bq,
  input  logic          rel_lq,
  input  logic          rel_sq,
  input  logic          squash_valid,
  input  logic [BP-1:0] squash_bq_ptr,
  input  logic [LP-1:0] squash_lq_ptr,
  input  logic [SP-1:0] squash_sq_ptr,
  output logic          bq_full_o,
  output logic          lq_full_o,
`ifdef ALLOC_CTRL_STATS_EN
  output logic          sq_full_o,
  output logic [31:0]   stall_bq_o,
  output logic [31:0]   stall_lq_o,
  output logic [31:0]   stall_sq_o
`else
  output logic          sq_full_o
`endif
);
  typedef enum logic {RUN, RECOVER} state_t;

  state_t        state_reg;
  logic          grant;
  logic [BP-2:0] bq_tail;
  logic [LP-2:0] lq_tail;
  logic [SP-2:0] sq_tail;

  always_ff @(posedge clk) begin
    if (!rstn)
      state_reg <= RUN;
    else if (squash_valid)
      state_reg <= RECOVER;
    else
      state_reg <= RUN;
  end

  // Readiness never looks at this cycle's releases: no bypass into a full queue.
  assign req_ready = rstn && (state_reg == RUN) && !squash_valid
                     && !(req_bq && bq_full_o)
                     && !(req_lq && lq_full_o)
                     && !(req_sq && sq_full_o);
  assign grant = req_valid && req_ready;

  assign bqid_o = req_bq ? bq_tail : '0;
  assign lqid_o = req_lq ? lq_tail : '0;
  assign sqid_o = req_sq ? sq_tail : '0;

  alloc_ring #(.DEPTH(BQ_DEPTH)) u_bq (
    .clk(clk), .rstn(rstn), .alloc(grant && req_bq), .rel(rel_bq),
    .squash_valid(squash_valid), .squash_ptr(squash_bq_ptr),
    .tail_idx(bq_tail), .full(bq_full_o)
  );

  alloc_ring #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk(clk), .rstn(rstn), .alloc(grant && req_lq), .rel(rel_lq),
    .squash_valid(squash_valid), .squash_ptr(squash_lq_ptr),
    .tail_idx(lq_tail), .full(lq_full_o)
  );

  alloc_ring #(.DEPTH(SQ_DEPTH)) u_sq (
    .clk(clk), .rstn(rstn), .alloc(grant && req_sq), .rel(rel_sq),
    .squash_valid(squash_valid), .squash_ptr(squash_sq_ptr),
    .tail_idx(sq_tail), .full(sq_full_o)
  );

`ifdef ALLOC_CTRL_STATS_EN
  logic [2:0]  req_vec;
  logic [2:0]  full_vec;
  logic [31:0] stall_reg [3];

  assign req_vec  = {req_sq, req_lq, req_bq};
  assign full_vec = {sq_full_o, lq_full_o, bq_full_o};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_stall
      always_ff @(posedge clk) begin
        if (!rstn)
          stall_reg[gi] <= '0;
        else if (req_valid && (state_reg == RUN) && !squash_valid
                 && req_vec[gi] && full_vec[gi] && (stall_reg[gi] != '1))
          stall_reg[gi] <= stall_reg[gi] + 32'd1;
      end
    end
  endgenerate

  assign stall_bq_o = stall_reg[0];
  assign stall_lq_o = stall_reg[1];
  assign stall_sq_o = stall_reg[2];
`endif
endmodule

// File: tb/tb_alloc_ctrl.sv
// Scoreboard bench for alloc_ctrl: directed test-plan sequences plus random
// traffic, checked against an occupancy/pointer model of each queue.

module tb_alloc_ctrl;
  localparam int BP = 4;
  localparam int LP = 5;
  localparam int SP = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_bq = 1'b0, req_lq = 1'b0, req_sq = 1'b0;
  logic          req_ready;
  logic [BP-2:0] bqid_o;
  logic [LP-2:0] lqid_o;
  logic [SP-2:0] sqid_o;
  logic          rel_bq = 1'b0, rel_lq = 1'b0, rel_sq = 1'b0;
  logic          squash_valid = 1'b0;
  logic [BP-1:0] squash_bq_ptr = '0;
  logic [LP-1:0] squash_lq_ptr = '0;
  logic [SP-1:0] squash_sq_ptr = '0;
  logic          bq_full_o, lq_full_o, sq_full_o;
`ifdef ALLOC_CTRL_STATS_EN
  logic [31:0]   stall_bq_o, stall_lq_o, stall_sq_o;
`endif

  always #5 clk = ~clk;

  alloc_ctrl #(.BQ_DEPTH(8), .LQ_DEPTH(16), .SQ_DEPTH(16)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid),
    .req_bq(req_bq), .req_lq(req_lq), .req_sq(req_sq), .req_ready(req_ready),
    .bqid_o(bqid_o), .lqid_o(lqid_o), .sqid_o(sqid_o),
    .rel_bq(rel_bq), .rel_lq(rel_lq), .rel_sq(rel_sq),
    .squash_valid(squash_valid), .squash_bq_ptr(squash_bq_ptr),
    .squash_lq_ptr(squash_lq_ptr), .squash_sq_ptr(squash_sq_ptr),
    .bq_full_o(bq_full_o), .lq_full_o(lq_full_o),
`ifdef ALLOC_CTRL_STATS_EN
    .sq_full_o(sq_full_o),
    .stall_bq_o(stall_bq_o), .stall_lq_o(stall_lq_o), .stall_sq_o(stall_sq_o)
`else
    .sq_full_o(sq_full_o)
`endif
  );

  typedef struct {
    bit        rn;
    bit        ready;
    bit        grant;
    bit [2:0]  req;
    bit [2:0]  full;
    int        id [3];
    bit [31:0] stall [3];
  } exp_t;

  exp_t      exp_q [$];
  int        n_cmp = 0;
  int        n_bad = 0;

  // Model: per queue, live-entry count and the next pointer to hand out (with wrap bit).
  int        dep [3] = '{8, 16, 16};
  int        occ [3] = '{0, 0, 0};
  int        tail_m [3] = '{0, 0, 0};
  bit [31:0] stall_m [3];
  bit        model_run = 1'b1;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic cycle(input bit rn, input bit v, input bit [2:0] rq, input bit [2:0] rl,
                       input bit sq, input int kb, input int kl, input int ks);
    exp_t     e;
    int       kreq [3];
    int       keep [3];
    int       ptr [3];
    int       drop;
    int       m;
    bit [2:0] rel_eff;
    bit       rdy;
    kreq[0] = kb; kreq[1] = kl; kreq[2] = ks;
    @(posedge clk);
    #1;
    rdy = rn && model_run && !sq;
    for (int i = 0; i < 3; i++) begin
      rel_eff[i] = rl[i] && (occ[i] > 0);
      keep[i] = occ[i] - int'(rel_eff[i]);
      if (kreq[i] >= 0 && kreq[i] < keep[i]) keep[i] = kreq[i];
      drop = occ[i] - int'(rel_eff[i]) - keep[i];
      m = 2 * dep[i];
      ptr[i] = ((tail_m[i] - drop) % m + m) % m;
      if (rq[i] && occ[i] == dep[i]) rdy = 1'b0;
      e.full[i]  = (occ[i] == dep[i]);
      e.id[i]    = tail_m[i] % dep[i];
      e.stall[i] = stall_m[i];
    end
    rstn = rn; req_valid = v;
    req_bq = rq[0]; req_lq = rq[1]; req_sq = rq[2];
    rel_bq = rel_eff[0]; rel_lq = rel_eff[1]; rel_sq = rel_eff[2];
    squash_valid = sq;
    squash_bq_ptr = BP'(ptr[0]);
    squash_lq_ptr = LP'(ptr[1]);
    squash_sq_ptr = SP'(ptr[2]);
    e.rn = rn; e.req = rq; e.ready = rdy; e.grant = v && rdy;
    exp_q.push_back(e);
    // Advance the model to the state after this clock edge.
    if (!rn) begin
      for (int i = 0; i < 3; i++) begin
        occ[i] = 0; tail_m[i] = 0; stall_m[i] = '0;
      end
      model_run = 1'b1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (v && model_run && !sq && rq[i] && occ[i] == dep[i] && stall_m[i] != 32'hFFFF_FFFF)
          stall_m[i] = stall_m[i] + 1;
        occ[i] = occ[i] - int'(rel_eff[i]);
        if (sq) begin
          occ[i] = keep[i];
          tail_m[i] = ptr[i];
        end else if (e.grant && rq[i]) begin
          occ[i] = occ[i] + 1;
          tail_m[i] = (tail_m[i] + 1) % (2 * dep[i]);
        end
      end
      model_run = !sq;
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    int   act_id [3];
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act_id[0] = int'(bqid_o); act_id[1] = int'(lqid_o); act_id[2] = int'(sqid_o);
        chk("req_ready", req_ready, e.ready);
        chk("bq_full", bq_full_o, e.full[0]);
        chk("lq_full", lq_full_o, e.full[1]);
        chk("sq_full", sq_full_o, e.full[2]);
        for (int i = 0; i < 3; i++)
          if (e.rn && e.req[i]) chk($sformatf("id[%0d]", i), act_id[i], e.id[i]);
`ifdef ALLOC_CTRL_STATS_EN
        chk("stall_bq", stall_bq_o, e.stall[0]);
        chk("stall_lq", stall_lq_o, e.stall[1]);
        chk("stall_sq", stall_sq_o, e.stall[2]);
`endif
        if (e.grant)
          $display("grant req=%b bq=%0d lq=%0d sq=%0d t=%0t", e.req,
                   e.req[0] ? e.id[0] : -1, e.req[1] ? e.id[1] : -1,
                   e.req[2] ? e.id[2] : -1, $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit [2:0] rq, rl;
    // Reset
    repeat (3) cycle(0, 0, 3'b000, 3'b000, 0, -1, -1, -1);
    // Fill BQ, observe back-pressure, release, wrapped index 0
    repeat (8) cycle(1, 1, 3'b001, 3'b000, 0, -1, -1, -1);
    cycle(1, 1, 3'b001, 3'b000, 0, -1, -1, -1);
    cycle(1, 1, 3'b001, 3'b001, 0, -1, -1, -1);
    cycle(1, 1, 3'b001, 3'b000, 0, -1, -1, -1);
    // Fill SQ, then LQ+SQ request is refused as a whole and stalls
    repeat (16) cycle(1, 1, 3'b100, 3'b000, 0, -1, -1, -1);
    repeat (3) cycle(1, 1, 3'b110, 3'b000, 0, -1, -1, -1);
    cycle(1, 1, 3'b010, 3'b000, 0, -1, -1, -1);
    // Full SQ with same-cycle release: no bypass; then grant+release keeps count
    cycle(1, 1, 3'b100, 3'b100, 0, -1, -1, -1);
    cycle(1, 1, 3'b100, 3'b100, 0, -1, -1, -1);
    cycle(1, 0, 3'b000, 3'b000, 0, -1, -1, -1);
    // Reset mid-run, then 5 BQ allocs and squash to ptr 2 with a release
    cycle(0, 1, 3'b111, 3'b000, 0, -1, -1, -1);
    cycle(1, 1, 3'b111, 3'b000, 0, -1, -1, -1);
    repeat (4) cycle(1, 1, 3'b001, 3'b000, 0, -1, -1, -1);
    cycle(1, 1, 3'b001, 3'b001, 1, 1, -1, -1);
    cycle(1, 1, 3'b001, 3'b000, 0, -1, -1, -1);
    cycle(1, 1, 3'b001, 3'b000, 0, -1, -1, -1);
    // Back-to-back squashes
    cycle(1, 1, 3'b001, 3'b000, 1, -1, -1, -1);
    cycle(1, 1, 3'b001, 3'b000, 1, -1, -1, -1);
    repeat (2) cycle(1, 1, 3'b001, 3'b000, 0, -1, -1, -1);
    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rq = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) rl[i] = ($urandom_range(0, 9) < 4);
      cycle($urandom_range(0, 299) != 0, $urandom_range(0, 9) != 0, rq, rl,
            $urandom_range(0, 29) == 0, $urandom_range(0, 15),
            $urandom_range(0, 15), $urandom_range(0, 15));
    end
    cycle(1, 0, 3'b000, 3'b000, 0, -1, -1, -1);
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
